// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the load/store path: funct3 encodings, LSU states,
// opcode values used by the controller, and request legality helpers.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Stores have no unsigned variants, so funct3[2] set on a store is illegal too.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (is_store && f3[2]);
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
               ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables, replicated store data and
// sign/zero-extended load data, all purely combinational.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] dmem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] rdata_shifted;

    always_comb begin
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    // Each lane carries the store byte that lands there for B/H/W sizes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_lane[8*gi +: 8] =
            (funct3[1:0] == 2'b00) ? wdata[7:0] :
            (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                     wdata[8*gi +: 8];
    end

    assign rdata_shifted = dmem_rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            F3_LH:   load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            F3_LBU:  load_data = {24'd0, rdata_shifted[7:0]};
            F3_LHU:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one MEM-stage op, runs a valid/ready request to data
// memory, waits for the response and stalls the pipeline until it completes.
module lsu
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [XLEN-1:0]   rdata,
    output logic              misaligned,
    output logic              access_err,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    lsu_state_t      state_reg, state_next;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] rdata_reg;
    logic [2:0]      funct3_reg;
    logic            we_reg;

    logic            accept;
    logic            rsp_take;
    logic [XLEN-1:0] load_data;

    lsu_align u_align (
        .funct3     (funct3_reg),
        .addr_lo    (addr_reg[1:0]),
        .wdata      (wdata_reg),
        .dmem_rdata (dmem_rdata),
        .be         (dmem_be),
        .wdata_lane (dmem_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_next     = state_reg;
        stall          = 1'b0;
        access_err     = 1'b0;
        misaligned     = 1'b0;
        accept         = 1'b0;
        rsp_take       = 1'b0;
        dmem_req_valid = 1'b0;
        load_valid     = 1'b0;
        case (state_reg)
            IDLE: begin
                // A store wins when both controls are high.
                if (mem_read || mem_write) begin
                    if (f3_illegal(funct3, mem_write)) begin
                        access_err = 1'b1;
                    end else if (addr_misaligned(funct3, addr[1:0])) begin
                        misaligned = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    rsp_take   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                load_valid = !we_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            funct3_reg <= '0;
            we_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg   <= addr;
                wdata_reg  <= wdata;
                funct3_reg <= funct3;
                we_reg     <= mem_write;
            end
            if (rsp_take && !we_reg) begin
                rdata_reg <= load_data;
            end
        end
    end

    assign rdata     = rdata_reg;
    assign dmem_we   = we_reg;
    assign dmem_addr = ADDR_W'({addr_reg[XLEN-1:2], 2'b00});

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level model predicts request fields,
// pulses and load results; a per-cycle monitor compares the DUT against it.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, load_valid, misaligned, access_err;
    logic [31:0] rdata;
    logic        dmem_req_valid, dmem_we;
    logic        dmem_req_ready = 1'b0;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .wdata          (wdata),
        .stall          (stall),
        .load_valid     (load_valid),
        .rdata          (rdata),
        .misaligned     (misaligned),
        .access_err     (access_err),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model expectations for the current op
    logic        exp_mis = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
    logic [3:0]  exp_be = 4'd0;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, exp_load = 32'd0;
    logic [31:0] rdata_hold = 32'd0;

    // monitor observations
    int          req_cyc = -100, lv_cyc = -100, lv_count = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] lat_addr = 32'd0, lat_wdata = 32'd0;
    logic [3:0]  lat_be = 4'd0;
    logic        lat_we = 1'b0;

    // memory responder controls
    int          ready_wait = 0;
    logic [31:0] rsp_word = 32'd0;
    logic        no_rsp = 1'b0, stale_rsp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level model: size from funct3, lanes by address offset.
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word);
        int size, off;
        logic [31:0] tmp;
        exp_err = 1'b0;
        exp_mis = 1'b0;
        if (!(rd || wr)) return;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (wr && f3[2])) begin
            exp_err = 1'b1;
            return;
        end
        size = 1 << f3[1:0];
        off  = int'(a[1:0]);
        if ((off % size) != 0) begin
            exp_mis = 1'b1;
            return;
        end
        exp_we   = wr;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_be   = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        tmp = word >> (8 * off);
        if (size == 1) tmp = f3[2] ? {24'd0, tmp[7:0]} : {{24{tmp[7]}}, tmp[7:0]};
        else if (size == 2) tmp = f3[2] ? {16'd0, tmp[15:0]} : {{16{tmp[15]}}, tmp[15:0]};
        exp_load = tmp;
    endtask

    // memory: ready after ready_wait cycles of valid, response the cycle after handshake
    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            if (dmem_req_valid) begin
                if (ready_wait > 0) begin
                    ready_wait--;
                    dmem_req_ready = 1'b0;
                end else begin
                    dmem_req_ready = 1'b1;
                end
            end else begin
                dmem_req_ready = 1'b0;
            end
            hs = dmem_req_valid && dmem_req_ready;
            @(posedge clk);
            #1;
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = (hs && !no_rsp) || stale_rsp;
            dmem_rdata     = hs ? rsp_word : 32'hA5A5_5A5A;
        end
    end

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rdata_hold = 32'd0;
                prev_valid = 1'b0;
            end else begin
                check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
                check("access_err", {31'd0, access_err}, {31'd0, exp_err});
                if (dmem_req_valid) begin
                    if (!prev_valid) req_cyc = cyc;
                    check("req_addr", dmem_addr, exp_addr);
                    check("req_be", {28'd0, dmem_be}, {28'd0, exp_be});
                    check("req_we", {31'd0, dmem_we}, {31'd0, exp_we});
                    if (exp_we) check("req_wdata", dmem_wdata, exp_wdata);
                    lat_addr = dmem_addr; lat_be = dmem_be; lat_we = dmem_we; lat_wdata = dmem_wdata;
                end
                prev_valid = dmem_req_valid;
                if (load_valid) begin
                    lv_cyc = cyc;
                    lv_count++;
                    check("load_valid_on_store", {31'd0, load_valid}, {31'd0, !exp_we});
                    if (!exp_we) rdata_hold = exp_load;
                end
                check("rdata", rdata, rdata_hold);
            end
        end
    end

    task automatic clear_inputs();
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clear_inputs();
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                          input int delay, output int t0);
        int stall_cnt, lv_before;
        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        model(rd, wr, f3, a, wd, word);
        rsp_word   = word;
        ready_wait = delay;
        t0         = cyc;
        lv_before  = lv_count;
        if (exp_err || exp_mis) begin
            @(negedge clk);
            check("drop_stall", {31'd0, stall}, 32'd0);
            check("drop_no_req", {31'd0, dmem_req_valid}, 32'd0);
            @(posedge clk);
            #1;
            clear_inputs();
            exp_err = 1'b0;
            exp_mis = 1'b0;
            #1;
            check("drop_no_load", 32'(lv_count - lv_before), 32'd0);
            $display("op rd=%0d wr=%0d f3=%0d addr=0x%08h dropped", rd, wr, f3, a);
            return;
        end
        stall_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall) break;
            stall_cnt++;
        end
        #1;
        check("stall_cycles", 32'(stall_cnt), 32'(3 + delay));
        check("req_latency", 32'(req_cyc - t0), 32'd1);
        if (!wr) check("load_latency", 32'(lv_cyc - t0), 32'(3 + delay));
        else     check("store_no_load", 32'(lv_count - lv_before), 32'd0);
        $display("op rd=%0d wr=%0d f3=%0d addr=0x%08h be=%b rdata=0x%08h stall_cycles=%0d",
                 rd, wr, f3, a, lat_be, rdata, stall_cnt);
    endtask

    initial begin
        int t0, t1, lv_before;

        // reset state
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1. LW aligned
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, t0);
        check("lit_lw_addr", lat_addr, 32'h100);
        check("lit_lw_be", {28'd0, lat_be}, 32'hF);
        check("lit_lw_rdata", rdata, 32'hDEADBEEF);

        // 2. LB / LBU top byte
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80123456, 0, t0);
        check("lit_lb_be", {28'd0, lat_be}, 32'h8);
        check("lit_lb_rdata", rdata, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80123456, 0, t0);
        check("lit_lbu_rdata", rdata, 32'h00000080);
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'hBEEF0000, 0, t0);
        check("lit_lh_rdata", rdata, 32'hFFFFBEEF);
        run_op(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, 32'h1234F00D, 0, t0);
        check("lit_lhu_rdata", rdata, 32'h0000F00D);

        // 3. SH upper half
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'd0, 0, t0);
        check("lit_sh_we", {31'd0, lat_we}, 32'd1);
        check("lit_sh_be", {28'd0, lat_be}, 32'hC);
        check("lit_sh_wdata", lat_wdata, 32'h12341234);
        check("lit_sh_rdata_kept", rdata, 32'h0000F00D);
        run_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'd0, 0, t0);
        check("lit_sb_wdata", lat_wdata, 32'hABABABAB);
        idle(1);

        // 4. dropped ops
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0, t0);
        run_op(1'b1, 1'b0, 3'b001, 32'h103, 32'd0, 32'd0, 0, t0);
        run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0, t0);
        run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 0, t0);
        run_op(1'b0, 1'b1, 3'b111, 32'h100, 32'd0, 32'd0, 0, t0);

        // 5a. back-pressure: ready low for 5 REQ cycles
        run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h11223344, 5, t0);
        check("lit_bp_rdata", rdata, 32'h11223344);
        idle(1);

        // 5b. reset while waiting for the response
        @(posedge clk);
        #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h104;
        model(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h55555555);
        rsp_word = 32'h55555555;
        ready_wait = 0;
        no_rsp = 1'b1;
        lv_before = lv_count;
        repeat (3) @(negedge clk);
        check("wait_stall", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_req", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_rsp = 1'b0;
        stale_rsp = 1'b1;
        @(negedge clk);
        check("stale_rsp_seen", {31'd0, dmem_rsp_valid}, 32'd1);
        check("stale_stall", {31'd0, stall}, 32'd0);
        stale_rsp = 1'b0;
        repeat (2) @(negedge clk);
        check("stale_no_load", 32'(lv_count - lv_before), 32'd0);
        check("stale_no_req", {31'd0, dmem_req_valid}, 32'd0);
        idle(1);

        // 6. back-to-back SW then LW, then read+write together
        run_op(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'd0, 0, t0);
        check("lit_sw_wdata", lat_wdata, 32'hCAFEF00D);
        run_op(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 32'h0BADC0DE, 0, t1);
        check("b2b_accept_gap", 32'(t1 - t0), 32'd4);
        check("b2b_req_cycle", 32'(req_cyc - t0), 32'd5);
        check("lit_b2b_rdata", rdata, 32'h0BADC0DE);
        run_op(1'b1, 1'b1, 3'b010, 32'h500, 32'h01020304, 32'hFFFFFFFF, 0, t0);
        check("both_is_store", {31'd0, lat_we}, 32'd1);
        check("both_rdata_kept", rdata, 32'h0BADC0DE);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
